// File: rtl/vfp_axis_pkg.sv
// Shared types for the D5M -> AXI4-Stream video packer.
// - axis_pix_t   : one stream beat as stored in the FIFO {user, last, data}
// - pack_state_t : frame-tracking FSM states
package vfp_axis_pkg;

  localparam int unsigned AXIS_DATA_WIDTH = 24;

  typedef struct packed {
    logic                       user;
    logic                       last;
    logic [AXIS_DATA_WIDTH-1:0] data;
  } axis_pix_t;

  typedef enum logic [1:0] {
    S_WAIT,
    S_IDLE,
    S_FRAME
  } pack_state_t;

endpackage

// File: rtl/vfp_sync_fifo.sv
// First-word-fall-through synchronous FIFO.
// Ports:
//   clk, rst        clock, async active-high reset
//   wr_en, wr_data  push request and word; accepted if not full or if popping this cycle
//   rd_en           pop request; ignored when empty
//   rd_data         head word, valid whenever !empty
//   full, empty     occupancy flags
//   level           current occupancy (0..DEPTH)
module vfp_sync_fifo #(
  parameter int unsigned WIDTH = 26,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q;
  logic             do_wr, do_rd;

  assign full    = (level_q == (AW+1)'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rd_data = mem[rd_ptr_q];

  // A full FIFO still takes a write when the head is leaving in the same cycle.
  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH for free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_wr && !do_rd) begin
        level_q <= level_q + 1'b1;
      end else if (!do_wr && do_rd) begin
        level_q <= level_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/d5m_axis_video_packer.sv
// D5M camera pixel stream to AXI4-Stream video (tuser = start of frame, tlast = end of line).
// The camera cannot be paused, so a FWFT FIFO absorbs back-pressure and overflow is only flagged.
// Ports:
//   pixclk, reset            clock, async active-high reset
//   ifval, ilval, idata      camera frame valid, line valid, pixel
//   m_axis_t*                AXI4-Stream master (tvalid/tready/tdata/tuser/tlast)
//   ovf                      sticky overflow flag, cleared only by reset
//   frame_cnt                completed frames, wrapping
//   fifo_level               FIFO occupancy
// DATA_WIDTH must match vfp_axis_pkg::AXIS_DATA_WIDTH (the beat struct is sized from it).
module d5m_axis_video_packer
  import vfp_axis_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = AXIS_DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                          pixclk,
  input  logic                          reset,
  input  logic                          ifval,
  input  logic                          ilval,
  input  logic [DATA_WIDTH-1:0]         idata,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tvalid,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tuser,
  output logic                          m_axis_tlast,
  output logic                          ovf,
  output logic [CNT_WIDTH-1:0]          frame_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  pack_state_t          state_q, state_d;
  logic                 sof_pend_q, sof_pend_d;
  logic                 hold_vld_q, hold_vld_d;
  axis_pix_t            hold_q, hold_d;
  logic                 ovf_q, ovf_d;
  logic [CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;

  logic                 pix_acc;
  logic                 push, pop;
  axis_pix_t            push_word, head_word;
  logic                 fifo_full, fifo_empty;

  assign pix_acc = (state_q == S_FRAME) & ifval & ilval;

  always_comb begin
    state_d     = state_q;
    sof_pend_d  = sof_pend_q;
    hold_vld_d  = hold_vld_q;
    hold_d      = hold_q;
    frame_cnt_d = frame_cnt_q;
    push        = 1'b0;
    push_word   = '0;

    unique case (state_q)
      // Wait for a frame gap so a frame already in progress at reset is never emitted.
      S_WAIT:  if (!ifval) state_d = S_WAIT == S_WAIT ? S_IDLE : S_WAIT;
      S_IDLE: begin
        if (ifval) begin
          state_d    = S_FRAME;
          sof_pend_d = 1'b1;
        end
      end
      S_FRAME: begin
        if (!ifval) begin
          state_d     = S_IDLE;
          frame_cnt_d = frame_cnt_q + 1'b1;
        end
      end
      default: state_d = S_WAIT;
    endcase

    // The hold register delays each pixel by one sample so tlast is known when it is pushed.
    if (pix_acc) begin
      if (hold_vld_q) begin
        push           = 1'b1;
        push_word      = hold_q;
        push_word.last = 1'b0;
      end
      hold_d      = '{user: sof_pend_q, last: 1'b0, data: idata};
      hold_vld_d  = 1'b1;
      sof_pend_d  = 1'b0;
    end else if (hold_vld_q) begin
      // Line (or frame) ended: the held pixel was the last of its line.
      push           = 1'b1;
      push_word      = hold_q;
      push_word.last = 1'b1;
      hold_vld_d     = 1'b0;
    end
  end

  assign pop   = m_axis_tvalid & m_axis_tready;
  // A push into a full FIFO is dropped unless the head leaves in the same cycle.
  assign ovf_d = ovf_q | (push & fifo_full & ~pop);

  always_ff @(posedge pixclk or posedge reset) begin
    if (reset) begin
      state_q     <= S_WAIT;
      sof_pend_q  <= 1'b0;
      hold_vld_q  <= 1'b0;
      hold_q      <= '0;
      ovf_q       <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      sof_pend_q  <= sof_pend_d;
      hold_vld_q  <= hold_vld_d;
      hold_q      <= hold_d;
      ovf_q       <= ovf_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  vfp_sync_fifo #(
    .WIDTH ($bits(axis_pix_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (pixclk),
    .rst     (reset),
    .wr_en   (push),
    .wr_data (push_word),
    .rd_en   (pop),
    .rd_data (head_word),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // Beat fields are forced to zero while empty so the unreset FIFO memory never shows.
  assign m_axis_tvalid = ~fifo_empty;
  assign m_axis_tdata  = fifo_empty ? '0   : head_word.data;
  assign m_axis_tuser  = fifo_empty ? 1'b0 : head_word.user;
  assign m_axis_tlast  = fifo_empty ? 1'b0 : head_word.last;
  assign ovf           = ovf_q;
  assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_d5m_axis_video_packer.sv
module tb_d5m_axis_video_packer;

  localparam int unsigned DW = 24;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW = 16;

  logic          pixclk = 1'b0;
  logic          reset  = 1'b1;
  logic          ifval  = 1'b0;
  logic          ilval  = 1'b0;
  logic [DW-1:0] idata  = '0;
  logic          m_axis_tready = 1'b0;
  logic          m_axis_tvalid;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tuser;
  logic          m_axis_tlast;
  logic          ovf;
  logic [CW-1:0] frame_cnt;
  logic [4:0]    fifo_level;

  d5m_axis_video_packer #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH),
    .CNT_WIDTH  (CW)
  ) dut (
    .pixclk        (pixclk),
    .reset         (reset),
    .ifval         (ifval),
    .ilval         (ilval),
    .idata         (idata),
    .m_axis_tready (m_axis_tready),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .ovf           (ovf),
    .frame_cnt     (frame_cnt),
    .fifo_level    (fifo_level)
  );

  always #5 pixclk = ~pixclk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Scoreboard of expected beats {user, last, data}
  logic [DW+1:0] exp_q [$];

  // Ready generation: fixed level or random per cycle
  logic rdy_fix  = 1'b0;
  logic rdy_rand = 1'b0;
  always @(posedge pixclk) begin
    #1;
    m_axis_tready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fix;
  end

  // Output monitor, sampled on the falling edge
  int            beats = 0;
  bit            prev_stall = 1'b0;
  logic [DW+1:0] prev_word;
  logic [DW+1:0] cur_word;
  logic [DW+1:0] mon_exp;

  always @(negedge pixclk) begin
    cur_word = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_tvalid", 64'(m_axis_tvalid), 64'd1);
        check("stall_word", 64'(cur_word), 64'(prev_word));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        beats++;
        check("beat_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          mon_exp = exp_q.pop_front();
          check("beat", 64'(cur_word), 64'(mon_exp));
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_word  = cur_word;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge pixclk);
    #1;
  endtask

  // Drive one frame of h lines of w pixels; expected beats recorded for the first max_push.
  task automatic drive_frame(input int w, input int h, input int max_push, input int chk_line);
    int pushed;
    logic [DW-1:0] d;
    pushed = 0;
    ifval = 1'b1;
    ilval = 1'b0;
    cyc(1);
    for (int l = 0; l < h; l++) begin
      for (int p = 0; p < w; p++) begin
        d = DW'($urandom);
        ilval = 1'b1;
        idata = d;
        if (pushed < max_push) begin
          exp_q.push_back({(l == 0 && p == 0), (p == w - 1), d});
          pushed++;
        end
        cyc(1);
      end
      ilval = 1'b0;
      idata = '0;
      cyc(2);
      if (l == chk_line) begin
        check("level_before_ovf", 64'(fifo_level), 64'd16);
        check("ovf_before_full_push", 64'(ovf), 64'd0);
      end
    end
    ifval = 1'b0;
    cyc(2);
  endtask

  task automatic drain(input string tag, input int max_cycles);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_axis_tvalid) && n < max_cycles) begin
      cyc(1);
      n++;
    end
    check(tag, 64'(exp_q.size() == 0 && !m_axis_tvalid), 64'd1);
  endtask

  int b0;

  initial begin
    // 1. reset state and a basic 4x3 frame
    cyc(3);
    reset = 1'b0;
    cyc(1);
    check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_tdata", 64'(m_axis_tdata), 64'd0);
    check("rst_level", 64'(fifo_level), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    rdy_fix = 1'b1;
    cyc(2);
    b0 = beats;
    drive_frame(4, 3, 1000, -1);
    drain("t1_drain", 200);
    check("t1_beats", 64'(beats - b0), 64'd12);
    check("t1_frame_cnt", 64'(frame_cnt), 64'd1);
    check("t1_ovf", 64'(ovf), 64'd0);

    // 2. back-pressure overflow: only the first 16 pixels survive
    rdy_fix = 1'b0;
    cyc(2);
    b0 = beats;
    drive_frame(4, 5, 16, 3);
    check("t2_level_full", 64'(fifo_level), 64'd16);
    check("t2_ovf", 64'(ovf), 64'd1);
    rdy_fix = 1'b1;
    drain("t2_drain", 200);
    check("t2_beats", 64'(beats - b0), 64'd16);
    check("t2_frame_cnt", 64'(frame_cnt), 64'd2);

    // 3. reset released mid-frame: that frame is discarded
    ifval = 1'b1;
    reset = 1'b1;
    cyc(2);
    exp_q.delete();
    reset = 1'b0;
    cyc(1);
    check("t3_ovf_cleared", 64'(ovf), 64'd0);
    b0 = beats;
    drive_frame(4, 2, 0, -1);
    check("t3_no_beats", 64'(beats - b0), 64'd0);
    check("t3_frame_cnt0", 64'(frame_cnt), 64'd0);
    cyc(2);
    drive_frame(4, 3, 1000, -1);
    drain("t3_drain", 200);
    check("t3_beats", 64'(beats - b0), 64'd12);
    check("t3_frame_cnt", 64'(frame_cnt), 64'd1);

    // 4. single-pixel lines
    b0 = beats;
    drive_frame(1, 3, 1000, -1);
    drain("t4_drain", 200);
    check("t4_beats", 64'(beats - b0), 64'd3);
    check("t4_frame_cnt", 64'(frame_cnt), 64'd2);

    // 5. line valid without frame valid is ignored; then random ready
    b0 = beats;
    for (int i = 0; i < 6; i++) begin
      ilval = i[0];
      idata = DW'($urandom);
      cyc(1);
    end
    ilval = 1'b0;
    cyc(3);
    check("t5_no_beats", 64'(beats - b0), 64'd0);
    check("t5_level", 64'(fifo_level), 64'd0);
    check("t5_frame_cnt", 64'(frame_cnt), 64'd2);
    rdy_rand = 1'b1;
    b0 = beats;
    drive_frame(4, 3, 1000, -1);
    drain("t5_drain", 1000);
    rdy_rand = 1'b0;
    rdy_fix  = 1'b1;
    check("t5_beats", 64'(beats - b0), 64'd12);
    check("t5_frame_cnt2", 64'(frame_cnt), 64'd3);

    // 6. reset with entries queued
    rdy_fix = 1'b0;
    cyc(2);
    drive_frame(5, 1, 1000, -1);
    check("t6_level5", 64'(fifo_level), 64'd5);
    check("t6_tvalid_pre", 64'(m_axis_tvalid), 64'd1);
    check("t6_frame_cnt_pre", 64'(frame_cnt), 64'd4);
    reset = 1'b1;
    #1;
    check("t6_tvalid_async", 64'(m_axis_tvalid), 64'd0);
    check("t6_level_async", 64'(fifo_level), 64'd0);
    check("t6_ovf", 64'(ovf), 64'd0);
    check("t6_frame_cnt", 64'(frame_cnt), 64'd0);
    exp_q.delete();
    cyc(2);
    reset = 1'b0;
    cyc(2);
    check("t6_tvalid_post", 64'(m_axis_tvalid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
